// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the fifo control blocks: FSM state encoding and
// width helpers for requester indices and counters.
package fifo_ctrl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Ceiling log2 that is usable in constant expressions (port and parameter widths).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) r++;
    return r;
  endfunction

  // Width of an index into n items, never less than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : clog2(n);
  endfunction

  localparam int NREQ_DEF  = 4;
  localparam int DSIZE_DEF = 4;
  localparam int BURST_DEF = 4;

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first requester at or after
// rr_ptr, wrapping from NREQ-1 back to 0.
module rr_pick
  import fifo_ctrl_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  int          cand;
  logic [IW-1:0] cand_idx;

  // Scan offsets from farthest to nearest so the closest hit to rr_ptr is the last one written.
  always_comb begin
    // NOTE: outputs and loop temporaries get a value before any conditional use, so no latch is inferred.
    valid    = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = IW'(cand);
      if (req[cand_idx]) begin
        valid = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Burst-granted round-robin arbiter for the single write port of the async
// fifo. One owner at a time gets up to BURST beats; an IDLE cycle separates
// grants so the next owner is chosen from a stable request vector.
module fifo_write_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int DSIZE = DSIZE_DEF,
  parameter int BURST = BURST_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*DSIZE-1:0]      data,
  output logic [NREQ-1:0]            ack,
  input  logic                       full,
  output logic                       winc,
  output logic [DSIZE-1:0]           wdata,
  output logic [idx_width(NREQ)-1:0] gnt_id,
  output logic                       busy
);

  localparam int             IW     = idx_width(NREQ);
  localparam int             BW     = idx_width(BURST + 1);
  localparam logic [BW-1:0]  LAST   = BW'(BURST - 1);
  localparam logic [IW-1:0]  MAX_ID = IW'(NREQ - 1);

  state_e           state_q, state_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]    beat_cnt_q, beat_cnt_d;
  logic [IW-1:0]    gnt_id_q, gnt_id_d;
  logic             pick_valid;
  logic [IW-1:0]    pick_idx;
  logic [IW-1:0]    next_ptr;
  logic             wr;
  logic [DSIZE-1:0] beats [NREQ];

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .valid  (pick_valid),
    .idx    (pick_idx)
  );

  // Unpack the flat data bus into one beat per requester for the owner mux.
  always_comb begin
    for (int i = 0; i < NREQ; i++) beats[i] = data[i*DSIZE +: DSIZE];
  end

  assign next_ptr = (gnt_id_q == MAX_ID) ? '0 : gnt_id_q + 1'b1;

  // Next-state logic: arbitrate in IDLE, accept/stall/release beats in GRANT.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    gnt_id_d   = gnt_id_q;
    wr         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_id_d   = pick_idx;
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        wr = req[gnt_id_q] & ~full;
        if (wr) begin
          if (beat_cnt_q == LAST) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end else if (!req[gnt_id_q]) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset; a mid-burst reset abandons the burst.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      gnt_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      gnt_id_q   <= gnt_id_d;
    end
  end

  // Write-port outputs are forced quiet while rst is high, before the reset edge lands.
  always_comb begin
    ack           = '0;
    ack[gnt_id_q] = wr & ~rst;
    winc          = wr & ~rst;
    wdata         = rst ? '0 : beats[gnt_id_q];
    busy          = (state_q == GRANT) & ~rst;
  end

  assign gnt_id = gnt_id_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter (NREQ=4, DSIZE=4, BURST=4).
// Inputs change 1ns after the rising edge; outputs are checked on the falling edge.
module tb_fifo_write_arbiter;
  import fifo_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [15:0] data = '0;
  logic        full = 1'b0;
  logic [3:0]  ack;
  logic        winc;
  logic [3:0]  wdata;
  logic [1:0]  gnt_id;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  always #5 clk = ~clk;

  fifo_write_arbiter #(.NREQ(4), .DSIZE(4), .BURST(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .data   (data),
    .ack    (ack),
    .full   (full),
    .winc   (winc),
    .wdata  (wdata),
    .gnt_id (gnt_id),
    .busy   (busy)
  );

  // Scoreboard: each write pairs with exactly one ack and carries that requester's data.
  always @(negedge clk) begin
    if (mon_en) begin
      n_checks++;
      if (winc !== |ack) begin
        n_fail++;
        $display("FAIL sb_winc_ack t=%0t winc=%b ack=%b", $time, winc, ack);
      end
      n_checks++;
      if ((ack & (ack - 4'd1)) !== 4'd0) begin
        n_fail++;
        $display("FAIL sb_onehot t=%0t ack=%b", $time, ack);
      end
      n_checks++;
      if (winc === 1'b1 && full === 1'b1) begin
        n_fail++;
        $display("FAIL sb_full_write t=%0t winc=1 full=1", $time);
      end
      for (int i = 0; i < 4; i++) begin
        if (winc === 1'b1 && ack[i] === 1'b1) begin
          n_checks++;
          if (wdata !== data[i*4 +: 4]) begin
            n_fail++;
            $display("FAIL sb_wdata t=%0t req=%0d wdata=%h want=%h", $time, i, wdata, data[i*4 +: 4]);
          end
        end
      end
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = '0;
    full = 1'b0;
    next_cyc();
    rst  = 1'b0;
  endtask

  task automatic test_reset();
    req  = 4'hF;
    full = 1'b0;
    data = 16'h4321;
    rst  = 1'b1;
    next_cyc();
    mon_en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      mid();
      n_checks++;
      if (winc !== 1'b0 || ack !== 4'b0) begin
        n_fail++;
        $display("FAIL reset_write c=%0d winc=%b ack=%b want 0/0000", c, winc, ack);
      end
      n_checks++;
      if (busy !== 1'b0 || gnt_id !== 2'd0) begin
        n_fail++;
        $display("FAIL reset_state c=%0d busy=%b gnt_id=%0d want 0/0", c, busy, gnt_id);
      end
      if (c == 2) begin
        rst = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || winc !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_release_idle busy=%b winc=%b want 0/0", busy, winc);
        end
      end
      next_cyc();
    end
    mid();
    n_checks++;
    if (ack !== 4'b0001 || winc !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_grant ack=%b winc=%b busy=%b want 0001/1/1", ack, winc, busy);
    end
  endtask

  task automatic test_single_burst();
    logic [3:0] d1    [7] = '{4'hA, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hE};
    bit         e_w   [7] = '{0, 1, 1, 1, 1, 0, 1};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      req  = 4'b0010;
      data = {8'h00, d1[c], 4'h0};
      mid();
      n_checks++;
      if (winc !== e_w[c] || ack !== (e_w[c] ? 4'b0010 : 4'b0000) || busy !== e_w[c]) begin
        n_fail++;
        $display("FAIL burst_ctl c=%0d winc=%b ack=%b busy=%b want winc=busy=%0d", c, winc, ack, busy, e_w[c]);
      end
      if (e_w[c]) begin
        n_checks++;
        if (wdata !== d1[c] || gnt_id !== 2'd1) begin
          n_fail++;
          $display("FAIL burst_data c=%0d wdata=%h gnt_id=%0d want %h/1", c, wdata, gnt_id, d1[c]);
        end
      end
      next_cyc();
    end
    req = '0;
  endtask

  task automatic test_fairness();
    int beats [4] = '{0, 0, 0, 0};
    int total = 0;
    int slot;
    bit ew;
    do_reset();
    req  = 4'hF;
    data = 16'h4321;
    for (int c = 0; c < 22; c++) begin
      slot = (c / 5) % 4;
      ew   = (c % 5) != 0;
      mid();
      n_checks++;
      if (winc !== ew || busy !== ew) begin
        n_fail++;
        $display("FAIL fair_ctl c=%0d winc=%b busy=%b want %0d", c, winc, busy, ew);
      end
      if (ew) begin
        n_checks++;
        if (gnt_id !== 2'(slot) || ack !== (4'b0001 << slot) || wdata !== 4'(slot + 1)) begin
          n_fail++;
          $display("FAIL fair_owner c=%0d gnt_id=%0d ack=%b wdata=%h want owner %0d", c, gnt_id, ack, wdata, slot);
        end
      end
      if (c < 20 && winc === 1'b1) begin
        total++;
        beats[gnt_id]++;
      end
      next_cyc();
    end
    n_checks++;
    if (total != 16) begin
      n_fail++;
      $display("FAIL fair_duty writes=%0d want 16 in 20 cycles", total);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (beats[i] != 4) begin
        n_fail++;
        $display("FAIL fair_beats owner=%0d beats=%0d want 4", i, beats[i]);
      end
    end
    req = '0;
  endtask

  task automatic test_backpressure();
    logic [3:0] d0  [9] = '{4'h1, 4'h1, 4'h2, 4'h3, 4'h3, 4'h3, 4'h3, 4'h4, 4'h4};
    bit         e_w [9] = '{0, 1, 1, 0, 0, 0, 1, 1, 0};
    bit         e_b [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
    int writes = 0;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      req  = 4'b0001;
      data = {12'h000, d0[c]};
      full = (c >= 3 && c <= 5);
      mid();
      n_checks++;
      if (winc !== e_w[c] || ack !== {3'b000, e_w[c]} || busy !== e_b[c]) begin
        n_fail++;
        $display("FAIL bp_ctl c=%0d winc=%b ack=%b busy=%b want %0d/%0d", c, winc, ack, busy, e_w[c], e_b[c]);
      end
      if (e_w[c]) begin
        n_checks++;
        if (wdata !== d0[c]) begin
          n_fail++;
          $display("FAIL bp_data c=%0d wdata=%h want %h", c, wdata, d0[c]);
        end
      end
      if (full) begin
        n_checks++;
        if (dut.beat_cnt_q !== 3'd2) begin
          n_fail++;
          $display("FAIL bp_hold c=%0d beat_cnt=%0d want 2", c, dut.beat_cnt_q);
        end
      end
      if (winc === 1'b1) writes++;
      next_cyc();
    end
    full = 1'b0;
    n_checks++;
    if (writes != 4) begin
      n_fail++;
      $display("FAIL bp_total writes=%0d want 4", writes);
    end
    req = '0;
  endtask

  task automatic test_early_release();
    logic [3:0] rq  [6] = '{4'b0100, 4'b1101, 4'b1101, 4'b1001, 4'b1001, 4'b1001};
    logic [3:0] e_a [6] = '{4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b1000};
    bit         e_b [6] = '{0, 1, 1, 1, 0, 1};
    do_reset();
    data = 16'h7509;
    for (int c = 0; c < 6; c++) begin
      req = rq[c];
      mid();
      n_checks++;
      if (ack !== e_a[c] || winc !== (e_a[c] != 4'b0) || busy !== e_b[c]) begin
        n_fail++;
        $display("FAIL early_ctl c=%0d ack=%b winc=%b busy=%b want %b/%0d", c, ack, winc, busy, e_a[c], e_b[c]);
      end
      if (c == 5) begin
        n_checks++;
        if (gnt_id !== 2'd3 || wdata !== 4'h7) begin
          n_fail++;
          $display("FAIL early_next gnt_id=%0d wdata=%h want 3/7", gnt_id, wdata);
        end
      end
      next_cyc();
    end
    req = '0;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    data = 16'h4321;
    for (int c = 0; c < 6; c++) begin
      req = (c < 3) ? 4'b0010 : 4'hF;
      rst = (c == 3);
      mid();
      if (c == 1 || c == 2) begin
        n_checks++;
        if (ack !== 4'b0010 || winc !== 1'b1) begin
          n_fail++;
          $display("FAIL rmb_beat c=%0d ack=%b winc=%b want 0010/1", c, ack, winc);
        end
      end
      if (c == 3) begin
        n_checks++;
        if (winc !== 1'b0 || ack !== 4'b0 || wdata !== 4'h0 || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL rmb_quiet winc=%b ack=%b wdata=%h busy=%b want 0", winc, ack, wdata, busy);
        end
      end
      if (c == 4) begin
        n_checks++;
        if (dut.state_q !== IDLE || dut.rr_ptr_q !== 2'd0 || busy !== 1'b0 || winc !== 1'b0) begin
          n_fail++;
          $display("FAIL rmb_idle state=%b rr_ptr=%0d busy=%b winc=%b want IDLE/0/0/0",
                   dut.state_q, dut.rr_ptr_q, busy, winc);
        end
      end
      if (c == 5) begin
        n_checks++;
        if (gnt_id !== 2'd0 || ack !== 4'b0001 || wdata !== 4'h1) begin
          n_fail++;
          $display("FAIL rmb_regrant gnt_id=%0d ack=%b wdata=%h want 0/0001/1", gnt_id, ack, wdata);
        end
      end
      next_cyc();
    end
    rst = 1'b0;
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_fairness();
    test_backpressure();
    test_early_release();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
